ram_dump_reader: RTL and testbench

- Bus-master readback engine: reads a block of words out of the byte-addressed RAM over the same enable/opcode/MFC handshake the control unit uses, then streams them out.
- Reassembles each word from 4 bytes, big-endian: Mem[a] is bits 31:24, Mem[a+3] is bits 7:0.
- Counterpart of the program loader path: loading writes words into Mem as bytes; this block reads them back as words for self-check and memory dump after a program run.
- Sits beside the datapath RAM port, muxed in while the CPU is halted.

---
 rtl/ram_dump_reader.sv | 164 ++++++++++++++++
 tb/tb_ram_dump_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump_reader.sv
// Bus-master readback engine: fetches a block of big-endian words from the byte RAM and streams them out.
// Optional MFC timeout is enabled by defining RAM_DUMP_TIMEOUT_EN.
module ram_dump_reader #(
    parameter int          ADDR_W         = 9,
    parameter int          CNT_W          = 8,
    parameter logic [5:0]  RD_BYTE_OP     = 6'b000000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              RAM_enable,
    output logic [5:0]        RAM_OpCode,
    output logic [ADDR_W-1:0] RAM_addr,
    input  logic [7:0]        RAM_Out,
    input  logic              MFC,
    output logic [31:0]       word_out,
    output logic [ADDR_W-1:0] word_addr,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_GAP,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;

`ifdef RAM_DUMP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            word_q      <= '0;
`ifdef RAM_DUMP_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
`ifdef RAM_DUMP_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        word_d      = word_q;
`ifdef RAM_DUMP_TIMEOUT_EN
        // Timer only counts consecutive waiting cycles of one ACCESS visit.
        tmo_d       = '0;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = {base_addr[ADDR_W-1:2], 2'b00};
                    remaining_d = word_count;
                    idx_d       = 2'd0;
`ifdef RAM_DUMP_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = (word_count == '0) ? S_FINISH : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (MFC) begin
                    case (idx_q)
                        2'd0:    word_d[31:24] = RAM_Out;
                        2'd1:    word_d[23:16] = RAM_Out;
                        2'd2:    word_d[15:8]  = RAM_Out;
                        default: word_d[7:0]   = RAM_Out;
                    endcase
                    if (idx_q == 2'd3) begin
                        state_d = S_EMIT;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_GAP;
                    end
                end else begin
`ifdef RAM_DUMP_TIMEOUT_EN
                    if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        word_d  = '0;
                        idx_d   = 2'd0;
                        state_d = S_FINISH;
                    end else begin
                        tmo_d   = tmo_q + TMO_W'(1);
                    end
`endif
                end
            end
            S_GAP: begin
                state_d = S_ACCESS;
            end
            S_EMIT: begin
                if (word_ready) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    addr_d      = addr_q + ADDR_W'(4);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state so they are glitch-free and zero in reset.
    always_comb begin
        RAM_enable = (state_q == S_ACCESS);
        RAM_OpCode = RAM_enable ? RD_BYTE_OP : 6'b000000;
        RAM_addr   = RAM_enable ? (addr_q + ADDR_W'(idx_q)) : '0;
        word_out   = word_q;
        word_addr  = addr_q;
        word_valid = (state_q == S_EMIT);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FINISH);
    end

`ifdef RAM_DUMP_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dump_reader.sv
// Scoreboard bench for ram_dump_reader: byte RAM model with programmable MFC delay plus a stalling consumer.
module tb_ram_dump_reader;

    localparam int ADDR_W = 9;
    localparam int CNT_W  = 8;

    logic              Clk = 1'b0;
    logic              RESET = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              RAM_enable;
    logic [5:0]        RAM_OpCode;
    logic [ADDR_W-1:0] RAM_addr;
    logic [7:0]        RAM_Out = 8'h00;
    logic              MFC = 1'b0;
    logic [31:0]       word_out;
    logic [ADDR_W-1:0] word_addr;
    logic              word_valid;
    logic              word_ready = 1'b1;
    logic              busy;
    logic              done;
    logic              err;

    ram_dump_reader #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_BYTE_OP(6'b000000), .TIMEOUT_CYCLES(64)
    ) dut (
        .Clk(Clk), .RESET(RESET), .start(start), .base_addr(base_addr), .word_count(word_count),
        .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode), .RAM_addr(RAM_addr), .RAM_Out(RAM_Out),
        .MFC(MFC), .word_out(word_out), .word_addr(word_addr), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [31:0]       exp_word_q [$];
    logic [ADDR_W-1:0] exp_waddr_q [$];
    logic [ADDR_W-1:0] exp_raddr_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int mfc_delay = 0;
    int ready_hold = 0;
    int acc_wait = 0;
    int emit_wait = 0;
    bit mfc_stuck = 1'b0;
    bit stray_mfc = 1'b0;
    bit prev_hold = 1'b0;
    bit prev_wait = 1'b0;
    logic [31:0]       prev_word = '0;
    logic [ADDR_W-1:0] prev_waddr = '0;
    logic [ADDR_W-1:0] prev_raddr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // RAM model, address monitor and consumer, all evaluated on the falling edge.
    always @(negedge Clk) begin
        cyc++;
        if (RAM_enable) begin
            if (!mfc_stuck && acc_wait >= mfc_delay) begin
                MFC     = 1'b1;
                RAM_Out = mem[RAM_addr];
            end else begin
                MFC     = 1'b0;
                RAM_Out = 8'($urandom);
            end
            acc_wait++;
        end else begin
            MFC      = stray_mfc;
            RAM_Out  = 8'($urandom);
            acc_wait = 0;
        end

        if (!RESET) begin
            if (RAM_enable && prev_wait)
                check("ram_addr_stable", RAM_addr, prev_raddr);
            if (RAM_enable && MFC) begin
                check("ram_opcode", RAM_OpCode, 6'b000000);
                if (exp_raddr_q.size() == 0)
                    check("extra_access", RAM_addr, 32'hFFFF_FFFF);
                else
                    check("ram_addr", RAM_addr, exp_raddr_q.pop_front());
            end
        end
        prev_wait  = RAM_enable && !MFC && !RESET;
        prev_raddr = RAM_addr;

        if (word_valid) begin
            if (emit_wait < ready_hold) begin
                word_ready = 1'b0;
                emit_wait++;
            end else begin
                word_ready = 1'b1;
            end
        end else begin
            word_ready = 1'b1;
            emit_wait  = 0;
        end

        if (!RESET) begin
            if (prev_hold) begin
                check("word_stable", word_out, prev_word);
                check("waddr_stable", word_addr, prev_waddr);
            end
            if (word_valid && first_valid_cyc < 0)
                first_valid_cyc = cyc;
            if (word_valid && word_ready) begin
                if (exp_word_q.size() == 0) begin
                    check("extra_word", word_out, 32'hDEAD_BEEF);
                end else begin
                    check("word_out", word_out, exp_word_q.pop_front());
                    check("word_addr", word_addr, exp_waddr_q.pop_front());
                end
            end
        end
        prev_hold  = word_valid && !word_ready && !RESET;
        prev_word  = word_out;
        prev_waddr = word_addr;
    end

    task automatic push_expect(input logic [ADDR_W-1:0] base, input int cnt);
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [31:0] w;
        a = {base[ADDR_W-1:2], 2'b00};
        for (int i = 0; i < cnt; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                b = a + ADDR_W'(k);
                w = {w[23:0], mem[b]};
                exp_raddr_q.push_back(b);
            end
            exp_word_q.push_back(w);
            exp_waddr_q.push_back(a);
            a = a + ADDR_W'(4);
        end
    endtask

    task automatic run(input logic [ADDR_W-1:0] base, input int cnt, input int dly, input int hold,
                       input bit mid_start, input string tag, output int done_n);
        int n;
        bit seen;
        mfc_delay  = dly;
        ready_hold = hold;
        push_expect(base, cnt);
        @(negedge Clk); #1;
        start = 1'b1; base_addr = base; word_count = CNT_W'(cnt);
        start_cyc = cyc; first_valid_cyc = -1;
        @(negedge Clk); #1;
        start = 1'b0; base_addr = ADDR_W'($urandom); word_count = CNT_W'($urandom);
        n = 1; seen = 1'b0;
        while (!seen && n < 3000) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = mid_start && (n == 3);
                if (start) begin base_addr = 9'h100; word_count = 8'd5; end
                @(negedge Clk); #1;
                start = 1'b0;
                n++;
            end
        end
        done_n = n;
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_done_busy"}, 32'(busy), 1);
        @(negedge Clk); #1;
        check({tag, "_idle_after"}, {done, busy}, 2'b00);
        check({tag, "_words_left"}, exp_word_q.size(), 0);
        check({tag, "_access_left"}, exp_raddr_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
        mem[0] = 8'h10; mem[1] = 8'h80; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h82; mem[5] = 8'h00; mem[6] = 8'h60; mem[7] = 8'h05;

        repeat (3) @(negedge Clk);
        #1;
        check("reset_ctrl", {RAM_enable, RAM_OpCode, word_valid, busy, done, err}, 0);
        check("reset_addr", RAM_addr, 0);
        check("reset_word", word_out, 0);
        check("reset_waddr", word_addr, 0);
        RESET = 1'b0;

        // Two known words from base 0, back-to-back consumer.
        run(9'h000, 2, 0, 0, 1'b0, "basic", dn);
        check("basic_first_latency", first_valid_cyc - start_cyc, 8);
        check("basic_done_cycle", dn, 17);

        // Zero-length request: FINISH straight away.
        run(9'h000, 0, 0, 0, 1'b0, "zero", dn);
        check("zero_done_cycle", dn, 1);

        // Unaligned base: low address bits dropped.
        push_expect(9'h006, 0);
        check("unaligned_exp_word", {mem[4], mem[5], mem[6], mem[7]}, 32'h82006005);
        run(9'h006, 1, 0, 0, 1'b0, "unaligned", dn);

        // Slow memory, stalling consumer, stray MFC in GAP, ignored start mid-transfer.
        stray_mfc = 1'b1;
        run(9'h040, 3, 3, 5, 1'b1, "slow", dn);
        stray_mfc = 1'b0;

        // Address wrap across the top of RAM.
        run(9'h1FC, 2, 1, 2, 1'b0, "wrap", dn);

        // Reset while the third byte is being fetched.
        mfc_delay = 0; ready_hold = 0;
        exp_raddr_q.push_back(9'h080); exp_raddr_q.push_back(9'h081); exp_raddr_q.push_back(9'h082);
        @(negedge Clk); #1;
        start = 1'b1; base_addr = 9'h080; word_count = 8'd1;
        @(negedge Clk); #1;
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!(RAM_enable && RAM_addr == 9'h082) && n < 50) begin
                @(negedge Clk); #1;
                n++;
            end
            check("rst_reached_byte2", 32'(n < 50), 1);
        end
        RESET = 1'b1;
        @(negedge Clk); #1;
        check("midrst_ctrl", {RAM_enable, RAM_OpCode, word_valid, busy, done, err}, 0);
        check("midrst_addr", RAM_addr, 0);
        check("midrst_word", word_out, 0);
        check("midrst_waddr", word_addr, 0);
        RESET = 1'b0;
        exp_raddr_q.delete(); exp_word_q.delete(); exp_waddr_q.delete();
        run(9'h080, 1, 0, 0, 1'b0, "after_rst", dn);

        // MFC never arrives.
        mfc_stuck = 1'b1;
        @(negedge Clk); #1;
        start = 1'b1; base_addr = 9'h010; word_count = 8'd1;
        @(negedge Clk); #1;
        start = 1'b0;
`ifdef RAM_DUMP_TIMEOUT_EN
        repeat (63) @(negedge Clk);
        #1;
        check("tmo_last_wait", {RAM_enable, err, done}, 3'b100);
        @(negedge Clk); #1;
        check("tmo_fire", {RAM_enable, err, done, busy}, 4'b0111);
        @(negedge Clk); #1;
        check("tmo_idle_sticky", {busy, err}, 2'b01);
        mfc_stuck = 1'b0;
        run(9'h000, 1, 0, 0, 1'b0, "tmo_clear", dn);
        check("tmo_err_cleared", err, 0);
`else
        repeat (100) @(negedge Clk);
        #1;
        check("no_tmo_waiting", {RAM_enable, busy, err, done}, 4'b1100);
        RESET = 1'b1;
        @(negedge Clk); #1;
        RESET = 1'b0;
        mfc_stuck = 1'b0;
        check("no_tmo_reset", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
